// File: rtl/morse_symbol_decoder.sv
// Morse symbol decoder: buffers up to five dot/dash presses and, after a letter gap,
// emits the A-Z / 0-9 character code on a valid/ready port. Optional macro: MORSE_DECODER_ABORT_EN.
module morse_symbol_decoder #(
    parameter int unsigned GAP_CYCLES = 50000000,
    parameter int unsigned GAP_WIDTH  = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] pushButton,
    output logic       charValid,
    input  logic       charReady,
    output logic [5:0] charCode,
    output logic [2:0] symbolCount,
    output logic       overflow
);

    // state     | meaning
    // S_IDLE    | buffer empty, waiting for the first symbol
    // S_COLLECT | symbols buffered, gap counter running
    // S_EMIT    | character presented, waiting for charReady
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT} state_t;

    state_t               state_q, state_d;
    logic [4:0]           pattern_q, pattern_d;
    logic [2:0]           count_q, count_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic [5:0]           code_q, code_d;
    logic [1:0]           prev_q, prev_d;

    logic dot_evt, dash_evt, single_evt, abort_evt;
    logic [5:0] lookup_code;

    assign dot_evt    = pushButton[1] & ~prev_q[1];
    assign dash_evt   = pushButton[0] & ~prev_q[0];
    assign single_evt = dot_evt ^ dash_evt;

`ifdef MORSE_DECODER_ABORT_EN
    assign abort_evt = dot_evt & dash_evt;
`else
    assign abort_evt = 1'b0;
`endif

    // Patterns are right-aligned, first symbol in the highest used bit, DASH = 1.
    always_comb begin
        lookup_code = 6'd63;
        if (!ovf_q) begin
            case ({count_q, pattern_q})
                {3'd2, 5'b00001}: lookup_code = 6'd0;
                {3'd4, 5'b01000}: lookup_code = 6'd1;
                {3'd4, 5'b01010}: lookup_code = 6'd2;
                {3'd3, 5'b00100}: lookup_code = 6'd3;
                {3'd1, 5'b00000}: lookup_code = 6'd4;
                {3'd4, 5'b00010}: lookup_code = 6'd5;
                {3'd3, 5'b00110}: lookup_code = 6'd6;
                {3'd4, 5'b00000}: lookup_code = 6'd7;
                {3'd2, 5'b00000}: lookup_code = 6'd8;
                {3'd4, 5'b00111}: lookup_code = 6'd9;
                {3'd3, 5'b00101}: lookup_code = 6'd10;
                {3'd4, 5'b00100}: lookup_code = 6'd11;
                {3'd2, 5'b00011}: lookup_code = 6'd12;
                {3'd2, 5'b00010}: lookup_code = 6'd13;
                {3'd3, 5'b00111}: lookup_code = 6'd14;
                {3'd4, 5'b00110}: lookup_code = 6'd15;
                {3'd4, 5'b01101}: lookup_code = 6'd16;
                {3'd3, 5'b00010}: lookup_code = 6'd17;
                {3'd3, 5'b00000}: lookup_code = 6'd18;
                {3'd1, 5'b00001}: lookup_code = 6'd19;
                {3'd3, 5'b00001}: lookup_code = 6'd20;
                {3'd4, 5'b00001}: lookup_code = 6'd21;
                {3'd3, 5'b00011}: lookup_code = 6'd22;
                {3'd4, 5'b01001}: lookup_code = 6'd23;
                {3'd4, 5'b01011}: lookup_code = 6'd24;
                {3'd4, 5'b01100}: lookup_code = 6'd25;
                {3'd5, 5'b11111}: lookup_code = 6'd26;
                {3'd5, 5'b01111}: lookup_code = 6'd27;
                {3'd5, 5'b00111}: lookup_code = 6'd28;
                {3'd5, 5'b00011}: lookup_code = 6'd29;
                {3'd5, 5'b00001}: lookup_code = 6'd30;
                {3'd5, 5'b00000}: lookup_code = 6'd31;
                {3'd5, 5'b10000}: lookup_code = 6'd32;
                {3'd5, 5'b11000}: lookup_code = 6'd33;
                {3'd5, 5'b11100}: lookup_code = 6'd34;
                {3'd5, 5'b11110}: lookup_code = 6'd35;
                default:          lookup_code = 6'd63;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        count_d   = count_q;
        gap_d     = gap_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        code_d    = code_q;
        prev_d    = pushButton;
        case (state_q)
            S_IDLE: begin
                if (single_evt) begin
                    pattern_d = {4'b0000, dash_evt};
                    count_d   = 3'd1;
                    gap_d     = '0;
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (abort_evt) begin
                    pattern_d = '0;
                    count_d   = '0;
                    ovf_d     = 1'b0;
                    gap_d     = '0;
                    state_d   = S_IDLE;
                end else if (single_evt) begin
                    if (count_q < 3'd5) begin
                        pattern_d = {pattern_q[3:0], dash_evt};
                        count_d   = count_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    gap_d = '0;
                end else if (gap_q == GAP_WIDTH'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    valid_d = 1'b1;
                    code_d  = lookup_code;
                    state_d = S_EMIT;
                end else begin
                    gap_d = gap_q + GAP_WIDTH'(1);
                end
            end
            S_EMIT: begin
                if (charReady) begin
                    valid_d   = 1'b0;
                    pattern_d = '0;
                    count_d   = '0;
                    ovf_d     = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            count_q   <= '0;
            gap_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            prev_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            prev_q    <= prev_d;
        end
    end

    assign charValid   = valid_q;
    assign charCode    = code_q;
    assign symbolCount = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Directed bench for morse_symbol_decoder with a 20-cycle letter gap.
module tb_morse_symbol_decoder;

    localparam int GAP = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] pushButton;
    logic       charValid;
    logic       charReady;
    logic [5:0] charCode;
    logic [2:0] symbolCount;
    logic       overflow;

    int compared   = 0;
    int mismatched = 0;
    int n;
    int nvalid;
    int code_seen;

    morse_symbol_decoder #(.GAP_CYCLES(GAP), .GAP_WIDTH(5)) dut (
        .clock(clock),
        .reset(reset),
        .pushButton(pushButton),
        .charValid(charValid),
        .charReady(charReady),
        .charCode(charCode),
        .symbolCount(symbolCount),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Event edge is the first tick; returns two cycles after it.
    task automatic send(input logic [1:0] b);
        pushButton = b;
        tick();
        tick();
        pushButton = 2'b00;
        tick();
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (charValid !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic count_valids(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (charValid === 1'b1) seen++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        pushButton = 2'b00;
        charReady  = 1'b1;
        repeat (3) tick();
        check("rst_valid", charValid, 0);
        check("rst_code", charCode, 0);
        check("rst_count", symbolCount, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick();

        // A: DOT 5 high, 3 low, then DASH
        pushButton = 2'b10;
        tick();
        check("a_count1", symbolCount, 1);
        repeat (4) tick();
        pushButton = 2'b00;
        repeat (3) tick();
        pushButton = 2'b01;
        tick();
        check("a_count2", symbolCount, 2);
        repeat (4) tick();
        pushButton = 2'b00;
        repeat (15) tick();
        check("a_valid_early", charValid, 0);
        tick();
        check("a_valid_at20", charValid, 1);
        check("a_code", charCode, 0);
        tick();
        check("a_valid_drop", charValid, 0);
        check("a_count_clr", symbolCount, 0);

        // digit 0: five dashes
        repeat (5) send(2'b01);
        check("zero_count", symbolCount, 5);
        check("zero_ovf", overflow, 0);
        wait_valid(40, n);
        check("zero_valid", charValid, 1);
        check("zero_latency", n, GAP - 2);
        check("zero_code", charCode, 26);
        tick();
        check("zero_drop", charValid, 0);

        // overflow: six dots
        repeat (6) send(2'b10);
        check("ovf_count", symbolCount, 5);
        check("ovf_flag", overflow, 1);
        wait_valid(40, n);
        check("ovf_valid", charValid, 1);
        check("ovf_code", charCode, 63);
        tick();
        check("ovf_clr", overflow, 0);
        check("ovf_count_clr", symbolCount, 0);

        // backpressure on E, DOT during EMIT dropped
        charReady = 1'b0;
        send(2'b10);
        wait_valid(40, n);
        check("bp_valid", charValid, 1);
        check("bp_code", charCode, 4);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) pushButton = 2'b10;
            if (i == 6) pushButton = 2'b00;
            tick();
            check("bp_hold_valid", charValid, 1);
            check("bp_hold_code", charCode, 4);
        end
        charReady = 1'b1;
        tick();
        check("bp_release", charValid, 0);
        check("bp_empty", symbolCount, 0);
        send(2'b01);
        check("t_count", symbolCount, 1);
        wait_valid(40, n);
        check("t_valid", charValid, 1);
        check("t_code", charCode, 19);
        tick();

        // DOT held 100 cycles
        pushButton = 2'b10;
        nvalid     = 0;
        code_seen  = 99;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (charValid === 1'b1) begin
                nvalid++;
                code_seen = charCode;
            end
        end
        pushButton = 2'b00;
        count_valids(30, n);
        check("held_emits", nvalid + n, 1);
        check("held_code", code_seen, 4);

        // simultaneous press from IDLE
        pushButton = 2'b11;
        tick();
        check("both_idle_count", symbolCount, 0);
        pushButton = 2'b00;
        count_valids(30, n);
        check("both_idle_noemit", n, 0);

        // simultaneous press after ".-"
        send(2'b10);
        send(2'b01);
        check("both_pre_count", symbolCount, 2);
        pushButton = 2'b11;
        tick();
`ifdef MORSE_DECODER_ABORT_EN
        check("abort_count", symbolCount, 0);
        pushButton = 2'b00;
        count_valids(30, n);
        check("abort_noemit", n, 0);
`else
        check("both_ignored_count", symbolCount, 2);
        pushButton = 2'b00;
        wait_valid(40, n);
        check("both_ignored_valid", charValid, 1);
        check("both_ignored_code", charCode, 0);
        tick();
`endif

        // reset mid-letter
        repeat (3) send(2'b10);
        check("rst_mid_pre", symbolCount, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_count", symbolCount, 0);
        count_valids(40, n);
        check("rst_mid_noemit", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
